// File: rtl/cz_flag_pkg.sv
// Shared types and defaults for the C/Z condition-flag pipeline.
package cz_flag_pkg;

   // Architectural flag values taken on reset.
   localparam logic RESET_CARRY_DEFAULT = 1'b0;
   localparam logic RESET_ZERO_DEFAULT  = 1'b0;

   // Flag update captured from EX and held in EX/MEM.
   typedef struct packed {
      logic valid;
      logic c_we;
      logic z_we;
      logic is_load;
      logic c;
      logic z;
   } flag_entry_t;

   // Flag update held in MEM/WB. The load's Z is already resolved by then,
   // so the load marker is no longer needed.
   typedef struct packed {
      logic valid;
      logic c_we;
      logic z_we;
      logic c;
      logic z;
   } wb_entry_t;

   localparam int FLAG_ENTRY_W = $bits(flag_entry_t);
   localparam int WB_ENTRY_W   = $bits(wb_entry_t);

   // Build the EX/MEM entry. A load never writes C, whatever the ALU control says.
   function automatic flag_entry_t make_ex_entry(
      input logic valid,
      input logic c_we,
      input logic z_we,
      input logic is_load,
      input logic c,
      input logic z
   );
      flag_entry_t e;
      e.valid   = valid;
      e.c_we    = c_we & ~is_load;
      e.z_we    = z_we;
      e.is_load = is_load;
      e.c       = c;
      e.z       = z;
      return e;
   endfunction

   // Advance an EX/MEM entry into MEM/WB, substituting the memory-derived Z for loads.
   function automatic wb_entry_t make_wb_entry(
      input flag_entry_t e,
      input logic        load_data_zero
   );
      wb_entry_t w;
      w.valid = e.valid;
      w.c_we  = e.c_we;
      w.z_we  = e.z_we;
      w.c     = e.c;
      w.z     = e.is_load ? load_data_zero : e.z;
      return w;
   endfunction

endpackage

// File: rtl/cz_flag_stage.sv
// One pipeline register for flag updates: holds on stall, clear wins over stall.
module cz_flag_stage #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Capture when the pipe advances; an all-zero entry is an invalid bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clear) begin
         q <= '0;
      end else if (!stall) begin
         q <= d;
      end
   end

endmodule

// File: rtl/cz_flag_file.sv
// Carry/zero flag file: pipelines flag updates from EX to WB, commits them to
// the architectural flags, forwards the youngest visible values to the ALU
// control and flags the load-Z hazard.
module cz_flag_file
   import cz_flag_pkg::*;
#(
   parameter logic RESET_CARRY = RESET_CARRY_DEFAULT,
   parameter logic RESET_ZERO  = RESET_ZERO_DEFAULT,
   parameter bit   FWD_EN      = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic stall,
   input  logic flush,
   input  logic ex_valid,
   input  logic ex_carry_we,
   input  logic ex_zero_we,
   input  logic ex_is_load,
   input  logic ex_carry,
   input  logic ex_zero,
   input  logic mem_load_data_zero,
   output logic carry_fwd,
   output logic zero_fwd,
   output logic arch_carry,
   output logic arch_zero,
   output logic z_load_hazard,
   output logic wb_carry_commit,
   output logic wb_zero_commit
);

   flag_entry_t ex_entry;
   flag_entry_t exmem;
   wb_entry_t   memwb_d;
   wb_entry_t   memwb;
   logic        wb_carry_write;
   logic        wb_zero_write;
   logic        exmem_carry_hit;
   logic        exmem_zero_hit;
   logic        memwb_carry_hit;
   logic        memwb_zero_hit;

   // A flushed EX instruction enters EX/MEM as a bubble.
   assign ex_entry = make_ex_entry(ex_valid & ~flush, ex_carry_we, ex_zero_we,
                                   ex_is_load, ex_carry, ex_zero);

   assign memwb_d = make_wb_entry(exmem, mem_load_data_zero);

   // Flush also clears EX/MEM while stalled so the squashed op cannot reappear.
   cz_flag_stage #(
      .W (FLAG_ENTRY_W)
   ) u_exmem (
      .clk   (clk),
      .rst   (rst),
      .stall (stall),
      .clear (flush),
      .d     (ex_entry),
      .q     (exmem)
   );

   cz_flag_stage #(
      .W (WB_ENTRY_W)
   ) u_memwb (
      .clk   (clk),
      .rst   (rst),
      .stall (stall),
      .clear (1'b0),
      .d     (memwb_d),
      .q     (memwb)
   );

   assign wb_carry_write = ~stall & memwb.valid & memwb.c_we;
   assign wb_zero_write  = ~stall & memwb.valid & memwb.z_we;

   // Commit WB updates to the architectural flags; pulses trace each commit edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arch_carry      <= RESET_CARRY;
         arch_zero       <= RESET_ZERO;
         wb_carry_commit <= 1'b0;
         wb_zero_commit  <= 1'b0;
      end else begin
         if (wb_carry_write) begin
            arch_carry <= memwb.c;
         end
         if (wb_zero_write) begin
            arch_zero <= memwb.z;
         end
         wb_carry_commit <= wb_carry_write;
         wb_zero_commit  <= wb_zero_write;
      end
   end

   // A load's Z is unknown until MEM data arrives, so it cannot be forwarded from EX/MEM.
   assign exmem_carry_hit = exmem.valid & exmem.c_we;
   assign exmem_zero_hit  = exmem.valid & exmem.z_we & ~exmem.is_load;
   assign memwb_carry_hit = memwb.valid & memwb.c_we;
   assign memwb_zero_hit  = memwb.valid & memwb.z_we;

   assign z_load_hazard = exmem.valid & exmem.is_load & exmem.z_we;

   // Per-flag forward select: youngest in-flight writer first, then architectural.
   always_comb begin
      carry_fwd = arch_carry;
      zero_fwd  = arch_zero;
      if (FWD_EN) begin
         if (exmem_carry_hit) begin
            carry_fwd = exmem.c;
         end else if (memwb_carry_hit) begin
            carry_fwd = memwb.c;
         end
         if (exmem_zero_hit) begin
            zero_fwd = exmem.z;
         end else if (memwb_zero_hit) begin
            zero_fwd = memwb.z;
         end
      end
   end

endmodule

// File: tb/tb_cz_flag_file.sv
// Directed-vector bench for cz_flag_file.
module tb_cz_flag_file;

   logic clk = 1'b0;
   logic rst, stall, flush;
   logic ex_valid, ex_carry_we, ex_zero_we, ex_is_load, ex_carry, ex_zero;
   logic mem_load_data_zero;
   logic carry_fwd, zero_fwd, arch_carry, arch_zero, z_load_hazard;
   logic wb_carry_commit, wb_zero_commit;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cz_flag_file dut (
      .clk                (clk),
      .rst                (rst),
      .stall              (stall),
      .flush              (flush),
      .ex_valid           (ex_valid),
      .ex_carry_we        (ex_carry_we),
      .ex_zero_we         (ex_zero_we),
      .ex_is_load         (ex_is_load),
      .ex_carry           (ex_carry),
      .ex_zero            (ex_zero),
      .mem_load_data_zero (mem_load_data_zero),
      .carry_fwd          (carry_fwd),
      .zero_fwd           (zero_fwd),
      .arch_carry         (arch_carry),
      .arch_zero          (arch_zero),
      .z_load_hazard      (z_load_hazard),
      .wb_carry_commit    (wb_carry_commit),
      .wb_zero_commit     (wb_zero_commit)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic cwe, input logic zwe,
                         input logic ld, input logic c, input logic z);
      ex_valid    = v;
      ex_carry_we = cwe;
      ex_zero_we  = zwe;
      ex_is_load  = ld;
      ex_carry    = c;
      ex_zero     = z;
   endtask

   task automatic idle();
      set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stall = 1'b0;
      flush = 1'b0;
      mem_load_data_zero = 1'b0;
   endtask

   task automatic apply_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      n_vec++; if (arch_carry !== 1'b0) begin n_err++; $display("FAIL rst_arch_carry: got %b want 0", arch_carry); end
      n_vec++; if (arch_zero !== 1'b0) begin n_err++; $display("FAIL rst_arch_zero: got %b want 0", arch_zero); end
      n_vec++; if (z_load_hazard !== 1'b0) begin n_err++; $display("FAIL rst_hazard: got %b want 0", z_load_hazard); end
      n_vec++; if (carry_fwd !== 1'b0 || zero_fwd !== 1'b0) begin n_err++; $display("FAIL rst_fwd: got c=%b z=%b want c=0 z=0", carry_fwd, zero_fwd); end
      n_vec++; if (wb_carry_commit !== 1'b0 || wb_zero_commit !== 1'b0) begin n_err++; $display("FAIL rst_commit: got c=%b z=%b want 0 0", wb_carry_commit, wb_zero_commit); end
      rst = 1'b0;
      $display("test_reset done");
   endtask

   // ADD with C=1, Z=0: visible via EX/MEM, MEM/WB, then architectural.
   task automatic test_add_latency();
      set_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      idle();
      n_vec++; if (carry_fwd !== 1'b1) begin n_err++; $display("FAIL add_t1_carry_fwd: got %b want 1", carry_fwd); end
      n_vec++; if (zero_fwd !== 1'b0) begin n_err++; $display("FAIL add_t1_zero_fwd: got %b want 0", zero_fwd); end
      n_vec++; if (arch_carry !== 1'b0) begin n_err++; $display("FAIL add_t1_arch_carry: got %b want 0", arch_carry); end
      tick();
      n_vec++; if (carry_fwd !== 1'b1) begin n_err++; $display("FAIL add_t2_carry_fwd: got %b want 1", carry_fwd); end
      n_vec++; if (arch_carry !== 1'b0) begin n_err++; $display("FAIL add_t2_arch_carry: got %b want 0", arch_carry); end
      tick();
      n_vec++; if (arch_carry !== 1'b1) begin n_err++; $display("FAIL add_t3_arch_carry: got %b want 1", arch_carry); end
      n_vec++; if (arch_zero !== 1'b0) begin n_err++; $display("FAIL add_t3_arch_zero: got %b want 0", arch_zero); end
      n_vec++; if (wb_carry_commit !== 1'b1 || wb_zero_commit !== 1'b1) begin n_err++; $display("FAIL add_t3_commit: got c=%b z=%b want 1 1", wb_carry_commit, wb_zero_commit); end
      tick();
      n_vec++; if (wb_carry_commit !== 1'b0 || wb_zero_commit !== 1'b0) begin n_err++; $display("FAIL add_t4_commit: got c=%b z=%b want 0 0", wb_carry_commit, wb_zero_commit); end
      n_vec++; if (carry_fwd !== 1'b1) begin n_err++; $display("FAIL add_t4_carry_fwd_arch: got %b want 1", carry_fwd); end
      $display("test_add_latency done");
   endtask

   // Reset asserted mid-run with arch_carry=1 and a load in EX/MEM.
   task automatic test_async_reset();
      set_ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      n_vec++; if (z_load_hazard !== 1'b1) begin n_err++; $display("FAIL arst_pre_hazard: got %b want 1", z_load_hazard); end
      rst = 1'b1;
      #2;
      n_vec++; if (arch_carry !== 1'b0 || arch_zero !== 1'b0) begin n_err++; $display("FAIL arst_arch: got c=%b z=%b want 0 0", arch_carry, arch_zero); end
      n_vec++; if (z_load_hazard !== 1'b0) begin n_err++; $display("FAIL arst_hazard: got %b want 0", z_load_hazard); end
      n_vec++; if (carry_fwd !== 1'b0 || zero_fwd !== 1'b0) begin n_err++; $display("FAIL arst_fwd: got c=%b z=%b want 0 0", carry_fwd, zero_fwd); end
      tick();
      rst = 1'b0;
      $display("test_async_reset done");
   endtask

   // ADD (C=1,Z=0) then NDU (Z only, Z=1): per-flag independent forwarding.
   task automatic test_add_ndu();
      apply_reset();
      set_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      n_vec++; if (carry_fwd !== 1'b1 || zero_fwd !== 1'b0) begin n_err++; $display("FAIL ndu_t1_fwd: got c=%b z=%b want 1 0", carry_fwd, zero_fwd); end
      tick();
      idle();
      n_vec++; if (carry_fwd !== 1'b1) begin n_err++; $display("FAIL ndu_t2_carry_fwd: got %b want 1", carry_fwd); end
      n_vec++; if (zero_fwd !== 1'b1) begin n_err++; $display("FAIL ndu_t2_zero_fwd: got %b want 1", zero_fwd); end
      tick();
      n_vec++; if (arch_carry !== 1'b1 || arch_zero !== 1'b0) begin n_err++; $display("FAIL ndu_t3_arch: got c=%b z=%b want 1 0", arch_carry, arch_zero); end
      n_vec++; if (zero_fwd !== 1'b1) begin n_err++; $display("FAIL ndu_t3_zero_fwd: got %b want 1", zero_fwd); end
      tick();
      n_vec++; if (arch_carry !== 1'b1 || arch_zero !== 1'b1) begin n_err++; $display("FAIL ndu_t4_arch: got c=%b z=%b want 1 1", arch_carry, arch_zero); end
      n_vec++; if (wb_carry_commit !== 1'b0 || wb_zero_commit !== 1'b1) begin n_err++; $display("FAIL ndu_t4_commit: got c=%b z=%b want 0 1", wb_carry_commit, wb_zero_commit); end
      $display("test_add_ndu done");
   endtask

   // Loads: Z comes from memory data; hazard for exactly one cycle; C never written.
   task automatic test_load();
      apply_reset();
      // LW #1: ALU zero=0, memory word is zero, c_we requested but must be dropped.
      set_ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      idle();
      mem_load_data_zero = 1'b1;
      n_vec++; if (z_load_hazard !== 1'b1) begin n_err++; $display("FAIL ld1_t1_hazard: got %b want 1", z_load_hazard); end
      n_vec++; if (carry_fwd !== 1'b0) begin n_err++; $display("FAIL ld1_t1_carry_fwd: got %b want 0", carry_fwd); end
      tick();
      mem_load_data_zero = 1'b0;
      n_vec++; if (z_load_hazard !== 1'b0) begin n_err++; $display("FAIL ld1_t2_hazard: got %b want 0", z_load_hazard); end
      n_vec++; if (zero_fwd !== 1'b1) begin n_err++; $display("FAIL ld1_t2_zero_fwd: got %b want 1", zero_fwd); end
      tick();
      n_vec++; if (arch_zero !== 1'b1 || arch_carry !== 1'b0) begin n_err++; $display("FAIL ld1_t3_arch: got c=%b z=%b want 0 1", arch_carry, arch_zero); end
      n_vec++; if (wb_carry_commit !== 1'b0 || wb_zero_commit !== 1'b1) begin n_err++; $display("FAIL ld1_t3_commit: got c=%b z=%b want 0 1", wb_carry_commit, wb_zero_commit); end
      // LW #2: ALU zero=0, memory word nonzero; while hazarded, zero_fwd falls back to arch (1).
      set_ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      n_vec++; if (z_load_hazard !== 1'b1) begin n_err++; $display("FAIL ld2_t1_hazard: got %b want 1", z_load_hazard); end
      n_vec++; if (zero_fwd !== 1'b1) begin n_err++; $display("FAIL ld2_t1_zero_skip: got %b want 1", zero_fwd); end
      tick();
      n_vec++; if (zero_fwd !== 1'b0) begin n_err++; $display("FAIL ld2_t2_zero_fwd: got %b want 0", zero_fwd); end
      tick();
      n_vec++; if (arch_zero !== 1'b0) begin n_err++; $display("FAIL ld2_t3_arch_zero: got %b want 0", arch_zero); end
      $display("test_load done");
   endtask

   // Flush squashes the EX instruction, alone and together with stall.
   task automatic test_flush();
      apply_reset();
      set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      flush = 1'b1;
      tick();
      idle();
      n_vec++; if (carry_fwd !== 1'b0) begin n_err++; $display("FAIL flush_t1_carry_fwd: got %b want 0", carry_fwd); end
      tick();
      tick();
      n_vec++; if (arch_carry !== 1'b0 || wb_carry_commit !== 1'b0) begin n_err++; $display("FAIL flush_t3_arch: got c=%b pulse=%b want 0 0", arch_carry, wb_carry_commit); end
      // Entry already in EX/MEM is cleared by flush even while stalled.
      set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      idle();
      n_vec++; if (carry_fwd !== 1'b1) begin n_err++; $display("FAIL flstall_pre_carry_fwd: got %b want 1", carry_fwd); end
      stall = 1'b1;
      flush = 1'b1;
      tick();
      idle();
      n_vec++; if (carry_fwd !== 1'b0) begin n_err++; $display("FAIL flstall_carry_fwd: got %b want 0", carry_fwd); end
      tick();
      tick();
      n_vec++; if (arch_carry !== 1'b0) begin n_err++; $display("FAIL flstall_arch_carry: got %b want 0", arch_carry); end
      $display("test_flush done");
   endtask

   // Entries in both stages held by a 3-cycle stall, then commit in order.
   task automatic test_stall();
      apply_reset();
      set_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      stall = 1'b1;
      n_vec++; if (carry_fwd !== 1'b1 || zero_fwd !== 1'b0) begin n_err++; $display("FAIL stall_pre_fwd: got c=%b z=%b want 1 0", carry_fwd, zero_fwd); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++; if (carry_fwd !== 1'b1 || zero_fwd !== 1'b0) begin n_err++; $display("FAIL stall_fwd[%0d]: got c=%b z=%b want 1 0", i, carry_fwd, zero_fwd); end
         n_vec++; if (arch_carry !== 1'b0 || arch_zero !== 1'b0) begin n_err++; $display("FAIL stall_arch[%0d]: got c=%b z=%b want 0 0", i, arch_carry, arch_zero); end
         n_vec++; if (wb_carry_commit !== 1'b0 || wb_zero_commit !== 1'b0) begin n_err++; $display("FAIL stall_commit[%0d]: got c=%b z=%b want 0 0", i, wb_carry_commit, wb_zero_commit); end
      end
      stall = 1'b0;
      tick();
      n_vec++; if (arch_carry !== 1'b1 || arch_zero !== 1'b1) begin n_err++; $display("FAIL stall_rel1_arch: got c=%b z=%b want 1 1", arch_carry, arch_zero); end
      n_vec++; if (wb_carry_commit !== 1'b1 || wb_zero_commit !== 1'b1) begin n_err++; $display("FAIL stall_rel1_commit: got c=%b z=%b want 1 1", wb_carry_commit, wb_zero_commit); end
      n_vec++; if (zero_fwd !== 1'b0) begin n_err++; $display("FAIL stall_rel1_zero_fwd: got %b want 0", zero_fwd); end
      tick();
      n_vec++; if (arch_carry !== 1'b1 || arch_zero !== 1'b0) begin n_err++; $display("FAIL stall_rel2_arch: got c=%b z=%b want 1 0", arch_carry, arch_zero); end
      n_vec++; if (wb_carry_commit !== 1'b0 || wb_zero_commit !== 1'b1) begin n_err++; $display("FAIL stall_rel2_commit: got c=%b z=%b want 0 1", wb_carry_commit, wb_zero_commit); end
      $display("test_stall done");
   endtask

   // Two back-to-back writers of both flags: EX/MEM must win over MEM/WB.
   task automatic test_back_to_back();
      apply_reset();
      set_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      set_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (carry_fwd !== 1'b1 || zero_fwd !== 1'b1) begin n_err++; $display("FAIL b2b_t1_fwd: got c=%b z=%b want 1 1", carry_fwd, zero_fwd); end
      tick();
      idle();
      n_vec++; if (carry_fwd !== 1'b0 || zero_fwd !== 1'b0) begin n_err++; $display("FAIL b2b_t2_fwd: got c=%b z=%b want 0 0", carry_fwd, zero_fwd); end
      tick();
      n_vec++; if (arch_carry !== 1'b1 || arch_zero !== 1'b1) begin n_err++; $display("FAIL b2b_t3_arch: got c=%b z=%b want 1 1", arch_carry, arch_zero); end
      n_vec++; if (carry_fwd !== 1'b0 || zero_fwd !== 1'b0) begin n_err++; $display("FAIL b2b_t3_fwd: got c=%b z=%b want 0 0", carry_fwd, zero_fwd); end
      tick();
      n_vec++; if (arch_carry !== 1'b0 || arch_zero !== 1'b0) begin n_err++; $display("FAIL b2b_t4_arch: got c=%b z=%b want 0 0", arch_carry, arch_zero); end
      $display("test_back_to_back done");
   endtask

   initial begin
      test_reset();
      test_add_latency();
      test_async_reset();
      test_add_ndu();
      test_load();
      test_flush();
      test_stall();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
